// File: rtl/branch_resolve_unit_if.sv
// Bus between the EX stage and the branch resolve unit. The master side is the
// pipeline/comparator environment; the slave side is branch_resolve_unit.
interface branch_resolve_unit_if #(
    parameter int CNT_W = 16
);
    logic             stall_i;
    logic             valid_ex_i;
    logic             is_branch_i;
    logic             is_jal_i;
    logic             is_jalr_i;
    logic [2:0]       funct3_i;
    logic             br_less_i;
    logic             br_equal_i;
    logic [31:0]      target_i;
    logic             br_unsigned_o;
    logic             redirect_o;
    logic [31:0]      redirect_pc_o;
    logic             flush_o;
    logic             illegal_o;
    logic [CNT_W-1:0] br_count_o;
    logic [CNT_W-1:0] taken_count_o;

    modport master (
        output stall_i, valid_ex_i, is_branch_i, is_jal_i, is_jalr_i, funct3_i,
               br_less_i, br_equal_i, target_i,
        input  br_unsigned_o, redirect_o, redirect_pc_o, flush_o, illegal_o,
               br_count_o, taken_count_o
    );

    modport slave (
        input  stall_i, valid_ex_i, is_branch_i, is_jal_i, is_jalr_i, funct3_i,
               br_less_i, br_equal_i, target_i,
        output br_unsigned_o, redirect_o, redirect_pc_o, flush_o, illegal_o,
               br_count_o, taken_count_o
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: decides branch/jump outcome in EX, issues a registered
// PC redirect and holds a pipeline flush for FLUSH_CYCLES cycles afterwards
// (static predict-not-taken). Keeps saturating resolved/taken branch counters.
module branch_resolve_unit #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    branch_resolve_unit_if.slave bus
);
    typedef enum logic {
        IDLE,
        FLUSH
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [2:0]       FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    state_e           state_q, state_d;
    logic [2:0]       flush_cnt_q, flush_cnt_d;
    logic             redirect_q, redirect_d;
    logic [31:0]      redirect_pc_q, redirect_pc_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] br_count_q, br_count_d;
    logic [CNT_W-1:0] taken_count_q, taken_count_d;

    logic cond;
    logic funct3_illegal;
    logic fire;
    logic is_jump;
    logic take;
    logic count_en;

    // Comparator select: unsigned compare only for BLTU/BGEU.
    assign bus.br_unsigned_o = (bus.funct3_i == 3'b110) || (bus.funct3_i == 3'b111);

    // Branch condition from comparator flags and funct3.
    always_comb begin
        cond           = 1'b0;
        funct3_illegal = 1'b0;
        case (bus.funct3_i)
            3'b000:  cond = bus.br_equal_i;
            3'b001:  cond = !bus.br_equal_i;
            3'b100:  cond = bus.br_less_i;
            3'b101:  cond = !bus.br_less_i;
            3'b110:  cond = bus.br_less_i;
            3'b111:  cond = !bus.br_less_i;
            default: funct3_illegal = 1'b1;
        endcase
    end

    // Decision: only a valid, unstalled instruction seen while not flushing counts.
    always_comb begin
        fire     = bus.valid_ex_i && !bus.stall_i && (state_q == IDLE);
        is_jump  = bus.is_jal_i || bus.is_jalr_i;
        take     = fire && (is_jump || (bus.is_branch_i && cond));
        count_en = fire && bus.is_branch_i && !funct3_illegal && !is_jump;
    end

    // FSM next state: a take starts a flush window timed by a down-counter.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            IDLE: begin
                if (take) begin
                    state_d     = FLUSH;
                    flush_cnt_d = FLUSH_INIT;
                end
            end
            FLUSH: begin
                if (flush_cnt_q == 3'd0) begin
                    state_d = IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q - 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Redirect, illegal pulse and saturating statistics next values.
    always_comb begin
        redirect_d    = take;
        redirect_pc_d = redirect_pc_q;
        illegal_d     = fire && bus.is_branch_i && funct3_illegal;
        br_count_d    = br_count_q;
        taken_count_d = taken_count_q;
        if (take) begin
            redirect_pc_d = bus.is_jalr_i ? {bus.target_i[31:1], 1'b0} : bus.target_i;
        end
        if (count_en && (br_count_q != CNT_MAX)) begin
            br_count_d = br_count_q + CNT_W'(1);
        end
        if (count_en && cond && (taken_count_q != CNT_MAX)) begin
            taken_count_d = taken_count_q + CNT_W'(1);
        end
    end

    // State and output registers; reset aborts any flush in progress.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            flush_cnt_q   <= 3'd0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= 32'd0;
            illegal_q     <= 1'b0;
            br_count_q    <= '0;
            taken_count_q <= '0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            illegal_q     <= illegal_d;
            br_count_q    <= br_count_d;
            taken_count_q <= taken_count_d;
        end
    end

    assign bus.redirect_o    = redirect_q;
    assign bus.redirect_pc_o = redirect_pc_q;
    assign bus.flush_o       = (state_q == FLUSH);
    assign bus.illegal_o     = illegal_q;
    assign bus.br_count_o    = br_count_q;
    assign bus.taken_count_o = taken_count_q;
endmodule
